// File: rtl/mc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_pkg
//   Shared encodings for the multi-cycle MIPS-subset control FSM: state
//   codes, opcode/funct values, ALU operation codes, mux selects, and the
//   per-state control word.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_ALUWB  = 4'd4,
    ST_MEMADR = 4'd5,
    ST_MEMRD  = 4'd6,
    ST_MEMWB  = 4'd7,
    ST_MEMWR  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12,
    ST_HALT   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word held for the current state. PC_WE/IR_WE are split into
  // qualifiers that are gated with MEM_READY / ZERO outside the register.
  typedef struct packed {
    logic       pc_we_uncond;
    logic       pc_we_fetch;
    logic       pc_we_branch;
    logic       ir_we_fetch;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Moore control word for a state; rtype_op is the FUNCT-decoded ALU op
  // used only in EXEC.
  function automatic ctrl_t state_ctrl(input state_e s, input logic [2:0] rtype_op);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_rd      = 1'b1;
        c.iord        = 1'b0;
        c.alu_srca    = 1'b0;
        c.alu_srcb    = SRCB_FOUR;
        c.alu_op      = ALU_ADD;
        c.pc_src      = PCSRC_ALU;
        c.pc_we_fetch = 1'b1;
        c.ir_we_fetch = 1'b1;
      end
      ST_DECODE: begin
        c.alu_srcb = SRCB_IMM_SH;
        c.alu_op   = ALU_ADD;
      end
      ST_EXEC: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SRCB_B;
        c.alu_op   = rtype_op;
      end
      ST_ALUWB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 1'b1;
      end
      ST_MEMADR, ST_ADDIEX: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SRCB_IMM;
        c.alu_op   = ALU_ADD;
      end
      ST_MEMRD: begin
        c.mem_rd = 1'b1;
        c.iord   = 1'b1;
      end
      ST_MEMWB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        c.mem_wr = 1'b1;
        c.iord   = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_srca     = 1'b1;
        c.alu_srcb     = SRCB_B;
        c.alu_op       = ALU_SUB;
        c.pc_src       = PCSRC_ALUOUT;
        c.pc_we_branch = 1'b1;
      end
      ST_ADDIWB: begin
        c.reg_we = 1'b1;
      end
      ST_JUMP: begin
        c.pc_src       = PCSRC_JUMP;
        c.pc_we_uncond = 1'b1;
      end
      ST_HALT: begin
        c.halted = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_alu_dec
//   Combinational R-type FUNCT to ALU_OP decoder with an illegal flag.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       illegal_o
);

  // Map supported FUNCT codes; anything else flags illegal and yields ADD.
  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for the multi-cycle MIPS-subset datapath (shared ALU,
//   unified memory port with a MEM_READY stall handshake).
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       PC_WE,
  output logic [1:0] PC_SRC,
  output logic       IOR_D,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       IR_WE,
  output logic       REG_DST,
  output logic       MEM_TO_REG,
  output logic       REG_WE,
  output logic       ALU_SRCA,
  output logic [1:0] ALU_SRCB,
  output logic [2:0] ALU_OP,
  output logic       HALTED,
  output logic [3:0] STATE
);
  import mc_pkg::*;

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [2:0] alu_op_dec;
  logic       funct_illegal;

  mc_alu_dec u_alu_dec (
    .funct_i   (FUNCT),
    .alu_op_o  (alu_op_dec),
    .illegal_o (funct_illegal)
  );

  // Next-state: instruction sequencing plus memory-ready stalls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  state_d = MEM_READY ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (OPCODE)
          OP_RTYPE: begin
            if (funct_illegal) state_d = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
            else               state_d = ST_EXEC;
          end
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
        endcase
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_MEMADR: begin
        if (OPCODE == OP_LW)      state_d = ST_MEMRD;
        else if (OPCODE == OP_SW) state_d = ST_MEMWR;
        else                      state_d = ST_FETCH;
      end
      ST_MEMRD:  state_d = MEM_READY ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = MEM_READY ? ST_FETCH : ST_MEMWR;
      ST_BRANCH: state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and control word registered together, so the outputs are
  // glitch-free and the async reset clears them along with the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d, alu_op_dec);
    end
  end

  // PC/IR writes in FETCH wait for the memory; the branch write waits on ZERO.
  assign PC_WE      = ctrl_q.pc_we_uncond
                    | (ctrl_q.pc_we_fetch  & MEM_READY)
                    | (ctrl_q.pc_we_branch & ZERO);
  assign IR_WE      = ctrl_q.ir_we_fetch & MEM_READY;
  assign PC_SRC     = ctrl_q.pc_src;
  assign IOR_D      = ctrl_q.iord;
  assign MEM_RD     = ctrl_q.mem_rd;
  assign MEM_WR     = ctrl_q.mem_wr;
  assign REG_DST    = ctrl_q.reg_dst;
  assign MEM_TO_REG = ctrl_q.mem_to_reg;
  assign REG_WE     = ctrl_q.reg_we;
  assign ALU_SRCA   = ctrl_q.alu_srca;
  assign ALU_SRCB   = ctrl_q.alu_srcb;
  assign ALU_OP     = ctrl_q.alu_op;
  assign HALTED     = ctrl_q.halted;
  assign STATE      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_op;
    logic       halted;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    string      name;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] OPCODE = '0;
  logic [5:0] FUNCT = '0;
  logic       ZERO = 1'b0;
  logic       MEM_READY = 1'b0;

  logic       pc_we1, ir_we1, iord1, mem_rd1, mem_wr1, reg_dst1, m2r1, reg_we1, srca1, halted1;
  logic [1:0] pc_src1, srcb1;
  logic [2:0] alu_op1;
  logic [3:0] state1;
  logic       pc_we0, ir_we0, iord0, mem_rd0, mem_wr0, reg_dst0, m2r0, reg_we0, srca0, halted0;
  logic [1:0] pc_src0, srcb0;
  logic [2:0] alu_op0;
  logic [3:0] state0;

  obs_t act1, act0;
  assign act1 = {state1, pc_we1, pc_src1, iord1, mem_rd1, mem_wr1, ir_we1, reg_dst1, m2r1,
                 reg_we1, srca1, srcb1, alu_op1, halted1};
  assign act0 = {state0, pc_we0, pc_src0, iord0, mem_rd0, mem_wr0, ir_we0, reg_dst0, m2r0,
                 reg_we0, srca0, srcb0, alu_op0, halted0};

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .PC_WE(pc_we1), .PC_SRC(pc_src1), .IOR_D(iord1), .MEM_RD(mem_rd1), .MEM_WR(mem_wr1),
    .IR_WE(ir_we1), .REG_DST(reg_dst1), .MEM_TO_REG(m2r1), .REG_WE(reg_we1),
    .ALU_SRCA(srca1), .ALU_SRCB(srcb1), .ALU_OP(alu_op1), .HALTED(halted1), .STATE(state1)
  );

  multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut_nop (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .PC_WE(pc_we0), .PC_SRC(pc_src0), .IOR_D(iord0), .MEM_RD(mem_rd0), .MEM_WR(mem_wr0),
    .IR_WE(ir_we0), .REG_DST(reg_dst0), .MEM_TO_REG(m2r0), .REG_WE(reg_we0),
    .ALU_SRCA(srca0), .ALU_SRCB(srcb0), .ALU_OP(alu_op0), .HALTED(halted0), .STATE(state0)
  );

  int   errors = 0;
  int   checks = 0;
  obs_t sb[$];
  vec_t vecs[$];

  // Reference outputs for a state, written from the state table.
  function automatic obs_t ref_outs(input logic [3:0] st, input logic [5:0] fn,
                                    input logic z, input logic rdy);
    obs_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd1:  begin e.mem_rd = 1; e.alu_srcb = 2'b01; e.ir_we = rdy; e.pc_we = rdy; end
      4'd2:  e.alu_srcb = 2'b11;
      4'd3:  begin
        e.alu_srca = 1;
        case (fn)
          6'h22:   e.alu_op = 3'b001;
          6'h24:   e.alu_op = 3'b010;
          6'h25:   e.alu_op = 3'b011;
          6'h2A:   e.alu_op = 3'b100;
          default: e.alu_op = 3'b000;
        endcase
      end
      4'd4:  begin e.reg_we = 1; e.reg_dst = 1; end
      4'd5:  begin e.alu_srca = 1; e.alu_srcb = 2'b10; end
      4'd6:  begin e.mem_rd = 1; e.iord = 1; end
      4'd7:  begin e.reg_we = 1; e.mem_to_reg = 1; end
      4'd8:  begin e.mem_wr = 1; e.iord = 1; end
      4'd9:  begin e.alu_srca = 1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_we = z; end
      4'd10: begin e.alu_srca = 1; e.alu_srcb = 2'b10; end
      4'd11: e.reg_we = 1;
      4'd12: begin e.pc_src = 2'b10; e.pc_we = 1; end
      4'd13: e.halted = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (state got %0d required %0d)",
               name, got, exp, got.st, exp.st);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [3:0] st, input string name);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare mid-cycle.
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [3:0] st, input string name);
    @(negedge CLK);
    OPCODE = op; FUNCT = fn; ZERO = z; MEM_READY = rdy;
    sb.push_back(ref_outs(st, fn, z, rdy));
    #1;
    check(name, act1, sb.pop_front());
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("reset_dut", act1, '0);
    check("reset_nop", act0, '0);
    @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    // R-type ALU ops; ZERO high must not leak into PC_WE
    add(6'h00, 6'h20, 1, 1, 1, "add_fetch");  add(6'h00, 6'h20, 1, 1, 2, "add_decode");
    add(6'h00, 6'h20, 1, 1, 3, "add_exec");   add(6'h00, 6'h20, 1, 1, 4, "add_wb");
    add(6'h00, 6'h22, 0, 1, 1, "sub_fetch");  add(6'h00, 6'h22, 0, 1, 2, "sub_decode");
    add(6'h00, 6'h22, 0, 1, 3, "sub_exec");   add(6'h00, 6'h22, 0, 1, 4, "sub_wb");
    add(6'h00, 6'h24, 0, 1, 1, "and_fetch");  add(6'h00, 6'h24, 0, 1, 2, "and_decode");
    add(6'h00, 6'h24, 0, 1, 3, "and_exec");   add(6'h00, 6'h24, 0, 1, 4, "and_wb");
    add(6'h00, 6'h25, 0, 1, 1, "or_fetch");   add(6'h00, 6'h25, 0, 1, 2, "or_decode");
    add(6'h00, 6'h25, 0, 1, 3, "or_exec");    add(6'h00, 6'h25, 0, 1, 4, "or_wb");
    add(6'h00, 6'h2A, 0, 1, 1, "slt_fetch");  add(6'h00, 6'h2A, 0, 1, 2, "slt_decode");
    add(6'h00, 6'h2A, 0, 1, 3, "slt_exec");   add(6'h00, 6'h2A, 0, 1, 4, "slt_wb");
    // LW: 2 stalls in FETCH, 3 in MEMRD -> 10 cycles
    add(6'h23, 6'h00, 0, 0, 1, "lw_fetch_stall"); add(6'h23, 6'h00, 0, 0, 1, "lw_fetch_stall");
    add(6'h23, 6'h00, 0, 1, 1, "lw_fetch");       add(6'h23, 6'h00, 0, 1, 2, "lw_decode");
    add(6'h23, 6'h00, 0, 1, 5, "lw_memadr");      add(6'h23, 6'h00, 0, 0, 6, "lw_memrd_stall");
    add(6'h23, 6'h00, 0, 0, 6, "lw_memrd_stall"); add(6'h23, 6'h00, 0, 0, 6, "lw_memrd_stall");
    add(6'h23, 6'h00, 0, 1, 6, "lw_memrd");       add(6'h23, 6'h00, 0, 1, 7, "lw_memwb");
    // BEQ taken and not taken
    add(6'h04, 6'h00, 1, 1, 1, "beq_t_fetch");    add(6'h04, 6'h00, 1, 1, 2, "beq_t_decode");
    add(6'h04, 6'h00, 1, 1, 9, "beq_t_branch");
    add(6'h04, 6'h00, 0, 1, 1, "beq_n_fetch");    add(6'h04, 6'h00, 0, 1, 2, "beq_n_decode");
    add(6'h04, 6'h00, 0, 1, 9, "beq_n_branch");
    // SW with two MEMWR stalls, then J
    add(6'h2B, 6'h00, 0, 1, 1, "sw_fetch");       add(6'h2B, 6'h00, 0, 1, 2, "sw_decode");
    add(6'h2B, 6'h00, 0, 0, 5, "sw_memadr");      add(6'h2B, 6'h00, 0, 0, 8, "sw_memwr_stall");
    add(6'h2B, 6'h00, 0, 0, 8, "sw_memwr_stall"); add(6'h2B, 6'h00, 0, 1, 8, "sw_memwr");
    add(6'h02, 6'h00, 0, 1, 1, "j_fetch");        add(6'h02, 6'h00, 0, 1, 2, "j_decode");
    add(6'h02, 6'h00, 0, 1, 12, "j_jump");
    // ADDI
    add(6'h08, 6'h00, 0, 1, 1, "addi_fetch");     add(6'h08, 6'h00, 0, 1, 2, "addi_decode");
    add(6'h08, 6'h00, 0, 1, 10, "addi_ex");       add(6'h08, 6'h00, 0, 1, 11, "addi_wb");

    // Reset state; MEM_READY high during reset is ignored
    MEM_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_idle", act1, '0);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].st, vecs[i].name);

    // Illegal opcode: halting variant parks, NOP variant keeps fetching
    for (int k = 0; k < 22; k++) begin
      obs_t e1, e0;
      @(negedge CLK);
      OPCODE = 6'h3F; FUNCT = 6'h00; ZERO = 1'b1; MEM_READY = 1'b1;
      #1;
      e1 = ref_outs((k == 0) ? 4'd1 : (k == 1) ? 4'd2 : 4'd13, 6'h00, 1'b1, 1'b1);
      e0 = ref_outs((k % 2 == 0) ? 4'd1 : 4'd2, 6'h00, 1'b1, 1'b1);
      check("illegal_halt", act1, e1);
      check("illegal_nop", act0, e0);
    end
    do_reset();

    // Unsupported R-type FUNCT also halts
    apply(6'h00, 6'h3F, 0, 1, 1, "badfn_fetch");
    apply(6'h00, 6'h3F, 0, 1, 2, "badfn_decode");
    apply(6'h00, 6'h3F, 0, 1, 13, "badfn_halt");
    do_reset();

    // Asynchronous reset mid-MEMRD, between clock edges
    apply(6'h23, 6'h00, 0, 1, 1, "rstlw_fetch");
    apply(6'h23, 6'h00, 0, 1, 2, "rstlw_decode");
    apply(6'h23, 6'h00, 0, 1, 5, "rstlw_memadr");
    apply(6'h23, 6'h00, 0, 0, 6, "rstlw_memrd");
    #2 RST = 1'b1;
    #1;
    check("async_reset_immediate", act1, '0);
    @(negedge CLK);
    #1;
    check("async_reset_hold", act1, '0);
    RST = 1'b0;
    apply(6'h23, 6'h00, 0, 1, 1, "after_reset_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
